duty_ctrl: RTL

- Button-driven producer of the X/Y servo duty-cycle words that feed the waypoint recorder's Duty_X/Duty_Y inputs.
- Debounces the four direction buttons and steps the duties with saturation.
- Auto-repeats on held buttons.
- Emits a one-cycle Store_Strobe on every accepted step, so the recorder captures exactly one sample per step.

---
 rtl/duty_ctrl_pkg.sv | 55 +++++
 rtl/duty_ctrl_if.sv | 28 ++
 rtl/duty_ctrl_btn_debounce.sv | 106 ++++++++++
 rtl/duty_ctrl.sv | 76 +++++++
 4 files changed

// File: rtl/duty_ctrl_pkg.sv
// Purpose : shared types, widths and helpers for the button-driven servo duty controller.
// Latency : n/a (package only).
// Backpress: n/a (package only).
package duty_ctrl_pkg;

    // Width of each servo duty word.
    localparam int DUTY_W = 6;

    // Signed width for the step arithmetic. Two guard bits above the duty
    // width keep DUTY_MAX+STEP positive, so an overflow can never alias to
    // a negative value and clamp to the wrong rail.
    localparam int CALC_W = DUTY_W + 2;

    // Button indices into the per-button vectors.
    localparam int BTN_N     = 4;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } btn_state_e;

    // Net signed delta for one axis: +step for inc only, -step for dec only,
    // zero when both or neither fire.
    function automatic logic signed [CALC_W-1:0] axis_delta(
        input logic              inc,
        input logic              dec,
        input logic [DUTY_W-1:0] step
    );
        logic signed [CALC_W-1:0] mag;
        mag = $signed({{(CALC_W-DUTY_W){1'b0}}, step});
        if (inc && !dec) return mag;
        if (dec && !inc) return -mag;
        return '0;
    endfunction

    // Apply a delta and clamp into [0, max_v]; never wraps.
    function automatic logic [DUTY_W-1:0] sat_add(
        input logic [DUTY_W-1:0]        cur,
        input logic signed [CALC_W-1:0] delta,
        input logic [DUTY_W-1:0]        max_v
    );
        logic signed [CALC_W-1:0] sum;
        sum = $signed({{(CALC_W-DUTY_W){1'b0}}, cur}) + delta;
        if (sum < 0) return '0;
        if (sum > $signed({{(CALC_W-DUTY_W){1'b0}}, max_v})) return max_v;
        return sum[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/duty_ctrl_if.sv
// Purpose : bundles the four raw direction buttons and the duty/strobe outputs.
// Latency : n/a (wires only).
// Backpress: none; buttons are level inputs and outputs are free-running.
// Signals : Bt_Up/Bt_Down/Bt_Left/Bt_Right raw buttons, Duty_X/Duty_Y duty
//           words, Store_Strobe one-cycle capture pulse for the recorder.
interface duty_ctrl_if;
    import duty_ctrl_pkg::*;

    logic              Bt_Up;
    logic              Bt_Down;
    logic              Bt_Left;
    logic              Bt_Right;
    logic [DUTY_W-1:0] Duty_X;
    logic [DUTY_W-1:0] Duty_Y;
    logic              Store_Strobe;

    // Button source / duty consumer side.
    modport master (
        output Bt_Up, Bt_Down, Bt_Left, Bt_Right,
        input  Duty_X, Duty_Y, Store_Strobe
    );

    // The duty controller itself.
    modport slave (
        input  Bt_Up, Bt_Down, Bt_Left, Bt_Right,
        output Duty_X, Duty_Y, Store_Strobe
    );
endinterface

// File: rtl/duty_ctrl_btn_debounce.sv
// Purpose : one button: 2-flop sync, debounce, then IDLE/FIRST/HOLD/REPEAT step generator.
// Latency : raw press to step_evt_o = 2 sync + DEBOUNCE_CYCLES + 1 (FIRST) cycles.
// Backpress: none; step_evt_o is a single-cycle pulse that must be consumed immediately.
// Ports   : clk_i, rst_ni (async active-low), btn_i raw button, step_evt_o step pulse.
module btn_debounce
    import duty_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic step_evt_o
);
    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HC_W     = $clog2(HOLD_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HC_W-1:0] DELAY_LAST = HC_W'(REPEAT_DELAY - 1);
    localparam logic [HC_W-1:0] RATE_LAST  = HC_W'(REPEAT_RATE - 1);

    logic [1:0]      sync_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            acc_q, acc_d;
    btn_state_e      state_q, state_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            db_cnt_q   <= '0;
            acc_q      <= 1'b0;
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
        end else begin
            sync_q     <= {sync_q[0], btn_i};
            db_cnt_q   <= db_cnt_d;
            acc_q      <= acc_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Debounce: the counter only advances while the synced input disagrees
    // with the accepted state; any agreement restarts the qualification.
    always_comb begin
        db_cnt_d = '0;
        acc_d    = acc_q;
        if (sync_q[1] != acc_q) begin
            if (db_cnt_q == DB_LAST) begin
                acc_d = ~acc_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    // Step generator. IDLE is only occupied while the accepted state is low,
    // so seeing it high in IDLE is exactly its rising edge.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        step_evt_o = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_q) state_d = ST_FIRST;
            end
            ST_FIRST: begin
                step_evt_o = 1'b1;
                state_d    = ST_HOLD;
                hold_cnt_d = '0;
            end
            ST_HOLD: begin
                if (hold_cnt_q == DELAY_LAST) begin
                    step_evt_o = 1'b1;
                    state_d    = ST_REPEAT;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            ST_REPEAT: begin
                if (hold_cnt_q == RATE_LAST) begin
                    step_evt_o = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
        // Release wins over everything and never produces a step.
        if (!acc_q) begin
            state_d    = ST_IDLE;
            hold_cnt_d = '0;
            step_evt_o = 1'b0;
        end
    end

endmodule

// File: rtl/duty_ctrl.sv
// Purpose : steps saturating X/Y servo duties from four debounced, auto-repeating buttons.
// Latency : raw press to duty+strobe = 2 + DEBOUNCE_CYCLES + 1 + 1 cycles.
// Backpress: none; Store_Strobe is a one-cycle pulse the recorder must capture.
// Ports   : sysclk, Reset_n (async active-low), bus (slave: buttons in,
//           Duty_X/Duty_Y/Store_Strobe out).
module duty_ctrl
    import duty_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter int STEP            = 1,
    parameter int DUTY_MAX        = 63,
    parameter int DUTY_INIT       = 32
) (
    input  logic        sysclk,
    input  logic        Reset_n,
    duty_ctrl_if.slave  bus
);
    localparam logic [DUTY_W-1:0] STEP_V = DUTY_W'(STEP);
    localparam logic [DUTY_W-1:0] MAX_V  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] INIT_V = DUTY_W'(DUTY_INIT);

    logic [BTN_N-1:0] btn_raw;
    logic [BTN_N-1:0] step_evt;

    assign btn_raw[BTN_UP]    = bus.Bt_Up;
    assign btn_raw[BTN_DOWN]  = bus.Bt_Down;
    assign btn_raw[BTN_LEFT]  = bus.Bt_Left;
    assign btn_raw[BTN_RIGHT] = bus.Bt_Right;

    for (genvar gi = 0; gi < BTN_N; gi++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_RATE     (REPEAT_RATE)
        ) u_btn (
            .clk_i      (sysclk),
            .rst_ni     (Reset_n),
            .btn_i      (btn_raw[gi]),
            .step_evt_o (step_evt[gi])
        );
    end

    logic signed [CALC_W-1:0] dx, dy;
    logic [DUTY_W-1:0]        duty_x_q, duty_x_d;
    logic [DUTY_W-1:0]        duty_y_q, duty_y_d;
    logic                     strobe_q, strobe_d;

    // The strobe follows the net delta, not the value change, so a press
    // against a rail is still logged as a dwell sample.
    always_comb begin
        dx       = axis_delta(step_evt[BTN_RIGHT], step_evt[BTN_LEFT], STEP_V);
        dy       = axis_delta(step_evt[BTN_UP],    step_evt[BTN_DOWN], STEP_V);
        duty_x_d = sat_add(duty_x_q, dx, MAX_V);
        duty_y_d = sat_add(duty_y_q, dy, MAX_V);
        strobe_d = (dx != '0) || (dy != '0);
    end

    always_ff @(posedge sysclk or negedge Reset_n) begin
        if (!Reset_n) begin
            duty_x_q <= INIT_V;
            duty_y_q <= INIT_V;
            strobe_q <= 1'b0;
        end else begin
            duty_x_q <= duty_x_d;
            duty_y_q <= duty_y_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.Duty_X       = duty_x_q;
    assign bus.Duty_Y       = duty_y_q;
    assign bus.Store_Strobe = strobe_q;

endmodule
